// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the sequential add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a one-bit counter to keep the port legal.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// One CHUNK-bit slice of the ripple add; the only carry path is CHUNK+1 bits wide.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/nbit_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LS chunk first.
// Optional ALU_SATURATE_EN: clamp the result to the signed limit on overflow.
module nbit_seq_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

`ifdef ALU_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cy_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             cout;
  logic             ovf_next;

  always_comb begin
    base    = CHUNK * int'(cnt_reg);
    a_chunk = a_reg[base +: CHUNK];
    b_chunk = b_reg[base +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (cy_reg),
    .sum  (sum_chunk),
    .cout (cout)
  );

  // Only meaningful on the last chunk, where sum_chunk holds the result MSB.
  assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (sum_chunk[CHUNK-1] != a_reg[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      out_reg       <= '0;
      cnt_reg       <= '0;
      cy_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= i1;
            b_reg        <= (op_sub == ALU_OP_SUB) ? ~i2 : i2;
            cy_reg       <= op_sub;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          out_reg[base +: CHUNK] <= sum_chunk;
          cy_reg                 <= cout;
          if (cnt_reg == LAST_CNT) begin
            cnt_reg       <= '0;
            ovf_reg       <= ovf_next;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
`ifdef ALU_SATURATE_EN
            if (ovf_next) begin
              out_reg <= a_reg[WIDTH-1] ? SAT_NEG : SAT_POS;
            end
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign carry     = cy_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nbit_seq_adder.sv
// Scoreboard bench for nbit_seq_adder: whole-width signed/unsigned reference model.
module tb_nbit_seq_adder;

  parameter int WIDTH = 32;
  parameter int CHUNK = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] out;
    bit               carry;
    bit               ovf;
    int               acc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ntx = 0;
  bit   seen = 0;
  bit   bp_mode = 1;
  bit   bp_val = 1;
  exp_t sb_q[$];

  nbit_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .i1        (i1),
    .i2        (i2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: unsigned carry and signed overflow from plain integer arithmetic.
  function automatic exp_t model(input bit sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, sres, lim;
    lim = longint'(1) << (WIDTH - 1);
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[WIDTH-1] ? ua - 2 * lim : ua;
    sb  = b[WIDTH-1] ? ub - 2 * lim : ub;
    if (!sub) begin
      e.out   = a + b;
      e.carry = (ua + ub) >= 2 * lim;
      sres    = sa + sb;
    end else begin
      e.out   = a - b;
      e.carry = ua >= ub;
      sres    = sa - sb;
    end
    e.ovf = (sres >= lim) || (sres < -lim);
`ifdef ALU_SATURATE_EN
    if (e.ovf) e.out = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return WIDTH'($urandom());
    endcase
  endfunction

  task automatic do_op(input bit sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      return;
    end
    e     = model(sub, a, b);
    e.acc = cyc + 1;
    sb_q.push_back(e);
    op_sub   = sub;
    i1       = a;
    i2       = b;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out"}, 64'(out), 64'd0);
    chk({tag, "_carry"}, 64'(carry), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2 out_ready = bp_mode ? bp_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on first sight of out_valid, values on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - sb_q[0].acc), 64'(NCHUNK));
          end
          if (out_ready) begin
            chk("out", 64'(out), 64'(sb_q[0].out));
            chk("carry", 64'(carry), 64'(sb_q[0].carry));
            chk("ovf", 64'(ovf), 64'(sb_q[0].ovf));
            $display("txn %0d: out=%h carry=%0d ovf=%0d", ntx, out, carry, ovf);
            ntx++;
            void'(sb_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    exp_t             bp_exp;
    logic [WIDTH-1:0] bp_a;
    logic [WIDTH-1:0] bp_b;
    int               n;

    rst      = 1;
    in_valid = 0;
    op_sub   = 0;
    i1       = '0;
    i2       = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;

    do_op(0, WIDTH'(138), WIDTH'(299));
    do_op(1, WIDTH'(5), WIDTH'(7));
    do_op(1, WIDTH'(72), WIDTH'(29));
    do_op(0, '1, WIDTH'(1));
    do_op(0, {1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1));
    do_op(1, {1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1));
    do_op(0, WIDTH'(100), WIDTH'(200));
    wait_drain();

    // Backpressure: result must hold and new operands must be ignored.
    bp_val = 0;
    bp_a   = WIDTH'(32'h1234_5678);
    bp_b   = WIDTH'(32'h1111_1111);
    bp_exp = model(0, bp_a, bp_b);
    do_op(0, bp_a, bp_b);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_stable", 64'(out), 64'(bp_exp.out));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_held", 64'(out_valid), 64'd1);
      op_sub   = 1;
      i1       = WIDTH'($urandom());
      i2       = WIDTH'($urandom());
      in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    bp_val   = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    wait_drain();

    // Abort an operation mid-RUN with an asynchronous reset pulse.
    do_op(0, WIDTH'(32'h0000_AAAA), WIDTH'(32'h0000_5555));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sb_q.delete();
    seen = 0;
    rst  = 1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 0;
    do_op(0, WIDTH'(1), WIDTH'(1));
    wait_drain();

    bp_mode = 0;
    for (int k = 0; k < 40; k++) begin
      do_op(1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
    end
    wait_drain();
    bp_mode = 1;
    bp_val  = 1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nbit_seq_adder.md
Name: nbit_seq_adder

Overview:
- Multi-cycle, parametrised add/subtract unit for the ALU.
- Processes WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, with the carry held in a register between chunks.
- Uses a valid/ready handshake on input and output, so the ALU controller can stall it.
- Replaces the single-cycle combinational adder where a wide operand would break timing.

Parameters:
- WIDTH, 32, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per clock; NCHUNK = WIDTH/CHUNK, and NCHUNK >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept operands.
- op_sub  input  1  0 = i1+i2, 1 = i1-i2.
- i1  input  WIDTH  operand A.
- i2  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  sum/difference.
- carry  output  1  carry out of MSB; for subtract, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, in_ready=1, out_valid=0, out=0, carry=0, ovf=0; chunk counter and carry register cleared.
- A reset asserted mid-operation aborts it, and no result is produced.
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch i1; latch i2 (bitwise inverted if op_sub); carry register = op_sub; counter = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add chunk[counter] of A, B and the carry register; write the sum into out[counter*CHUNK +: CHUNK]; update the carry register; counter++.
  - After chunk NCHUNK-1 completes, go to HOLD with out_valid=1.
- HOLD:
  - out_valid=1, in_ready=0.
  - out/carry/ovf stay stable until out_ready=1.
  - On out_ready: out_valid=0, go to IDLE.
  - out keeps its last value until the next operation overwrites it.
- Latency: accept edge to out_valid = NCHUNK cycles. Throughput: one operation per NCHUNK+2 cycles with out_ready tied high.
- carry = final carry register.
- ovf = (A[MSB]==B'[MSB]) && (out[MSB]!=A[MSB]), where B' is the possibly inverted i2.
- All arithmetic is modulo 2^WIDTH.
- No internal widening beyond CHUNK+1 bits per slice.
- in_valid in RUN/HOLD is ignored; the upstream must hold it until in_ready.
- out_ready in IDLE/RUN is ignored.
- NCHUNK=1: single RUN cycle, latency 1.
- out is visibly partially written during RUN; it is only meaningful when out_valid=1.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined:
  - When ovf=1 at completion, out is forced to the signed limit: 0x7FF..F if A[MSB]==0, else 0x800..0.
  - ovf is still reported.
  - The force is applied on the RUN->HOLD transition, so latency is unchanged.
- Undefined: result wraps modulo 2^WIDTH; no saturation logic is present.

Decomposition:
- Package alu_pkg:
  - State encoding type (IDLE=2'd0, RUN=2'd1, HOLD=2'd2).
  - Op encoding constants ALU_OP_ADD=1'b0, ALU_OP_SUB=1'b1.
  - Function computing NCHUNK and the counter width ($clog2(NCHUNK), minimum 1).
- Sub-module chunk_adder:
  - Combinational, parameter CHUNK.
  - Ports a, b, cin, sum, cout.
  - Instantiated once; the chunk is muxed in by the counter.

Test Plan (WIDTH=32, CHUNK=8):
- Reset, then add i1=138, i2=299 -> out_valid 4 cycles after accept; out=437, carry=0, ovf=0.
- Subtract i1=5, i2=7 -> out=0xFFFFFFFE, carry=0, ovf=0; a second op 72-29 -> out=43, carry=1.
- Add 0xFFFFFFFF+1 -> out=0, carry=1, ovf=0. Add 0x7FFFFFFF+1 -> ovf=1; out=0x80000000, or 0x7FFFFFFF with ALU_SATURATE_EN.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
- Assert rst for 1 cycle during RUN (counter=2) -> all outputs 0, in_ready=1 immediately; next op 1+1 -> out=2.
- Rebuild with CHUNK=32 (NCHUNK=1) and add 100+200 -> out=300 one cycle after accept.
